collision_arbiter: RTL and testbench

- Parametrised, multi-channel successor to the two-port collision lookup scheme.
- Time-multiplexes N_CH entity tile queries (player, blade, future enemies/projectiles) onto one shared level read port.
- Uses round-robin arbitration and a pipelined, tagged lookup path, with a per-channel result register and done strobe.
- Sits between the entity modules and `level`, and frees the other level ports for display.

---
 rtl/collision_arbiter_pkg.sv | 32 +++
 rtl/collision_arbiter_if.sv | 36 +++
 rtl/collision_arbiter_rr.sv | 44 ++++
 rtl/collision_arbiter.sv | 131 +++++++++++++
 tb/tb_collision_arbiter.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/collision_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// sk_defs : shared tile/channel definitions for the collision lookup path
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package sk_defs;

  localparam int SK_COORD_W = 10;
  localparam int SK_TYPE_W  = 3;

  typedef enum logic [2:0] {
    BLK_EMPTY  = 3'd0,
    BLK_SOLID  = 3'd1,
    BLK_SPIKE  = 3'd2,
    BLK_LADDER = 3'd3,
    BLK_GOAL   = 3'd4
  } blk_type_e;

  localparam int CH_PLAYER = 0;
  localparam int CH_BLADE  = 1;
  localparam int CH_ENEMY0 = 2;
  localparam int CH_ENEMY1 = 3;

  // Index width for an N-entry channel set, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/collision_arbiter_if.sv
// ---------------------------------------------------------------------------
// collision_arbiter_if : entity-side request/result bundle for the arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface collision_arbiter_if
  import sk_defs::*;
#(
  parameter int N_CH    = 4,
  parameter int COORD_W = SK_COORD_W,
  parameter int TYPE_W  = SK_TYPE_W
);

  logic [N_CH-1:0]         ch_en;
  logic [N_CH-1:0]         req;
  logic [N_CH*COORD_W-1:0] req_x;
  logic [N_CH*COORD_W-1:0] req_y;
  logic [N_CH-1:0]         gnt;
  logic [N_CH-1:0]         done;
  logic [N_CH*TYPE_W-1:0]  result;
  logic [N_CH-1:0]         busy;

  modport master (
    output ch_en, req, req_x, req_y,
    input  gnt, done, result, busy
  );

  modport slave (
    input  ch_en, req, req_x, req_y,
    output gnt, done, result, busy
  );

endinterface

`default_nettype wire

// File: rtl/collision_arbiter_rr.sv
// ---------------------------------------------------------------------------
// rr_arbiter : combinational round-robin picker, search starts at i_ptr
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  i_elig,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic          o_any,
  output logic [PW-1:0] o_idx,
  output logic [PW-1:0] o_next_ptr
);

  logic [PW-1:0] w_cand;

  always_comb begin
    o_gnt  = '0;
    o_any  = 1'b0;
    o_idx  = '0;
    w_cand = '0;
    for (int k = 0; k < N; k++) begin
      w_cand = PW'((int'(i_ptr) + k) % N);
      if (!o_any && i_elig[w_cand]) begin
        o_any = 1'b1;
        o_idx = w_cand;
      end
    end
    if (o_any) begin
      o_gnt[o_idx] = 1'b1;
    end
  end

  assign o_next_ptr = !o_any                  ? i_ptr :
                      (o_idx == PW'(N - 1))   ? '0    :
                                                o_idx + 1'b1;

endmodule

`default_nettype wire

// File: rtl/collision_arbiter.sv
// ---------------------------------------------------------------------------
// collision_arbiter : round-robin multiplexing of N_CH tile queries onto one
//                     level read port with a tagged latency-matched pipeline
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module collision_arbiter
  import sk_defs::*;
#(
  parameter int N_CH    = 4,
  parameter int COORD_W = SK_COORD_W,
  parameter int TYPE_W  = SK_TYPE_W,
  parameter int LVL_LAT = 1
) (
  input  logic               clk,
  input  logic               reset,
  collision_arbiter_if.slave bus,
  output logic [COORD_W-1:0] lvl_x,
  output logic [COORD_W-1:0] lvl_y,
  input  logic [TYPE_W-1:0]  lvl_data
);

  localparam int PW    = idx_w(N_CH);
  localparam int DEPTH = LVL_LAT + 1;

  logic [N_CH-1:0]    w_elig;
  logic [N_CH-1:0]    w_gnt;
  logic [N_CH-1:0]    w_cpl_oh;
  logic               w_any;
  logic [PW-1:0]      w_idx;
  logic [PW-1:0]      w_next_ptr;
  logic               w_cpl;
  logic [PW-1:0]      w_cpl_tag;

  logic [PW-1:0]      r_ptr;
  logic [N_CH-1:0]    r_gnt;
  logic [N_CH-1:0]    r_done;
  logic [N_CH-1:0]    r_busy;
  logic [COORD_W-1:0] r_lvl_x;
  logic [COORD_W-1:0] r_lvl_y;
  logic [DEPTH-1:0]   r_vld;
  logic [PW-1:0]      r_tag    [DEPTH];
  logic [TYPE_W-1:0]  r_result [N_CH];

  // Registered busy keeps a completing channel ineligible until the next cycle.
  assign w_elig = bus.req & bus.ch_en & ~r_busy;

  rr_arbiter #(
    .N  (N_CH),
    .PW (PW)
  ) u_rr (
    .i_elig     (w_elig),
    .i_ptr      (r_ptr),
    .o_gnt      (w_gnt),
    .o_any      (w_any),
    .o_idx      (w_idx),
    .o_next_ptr (w_next_ptr)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr   <= '0;
      r_gnt   <= '0;
      r_lvl_x <= '0;
      r_lvl_y <= '0;
    end else begin
      r_gnt <= w_gnt;
      if (w_any) begin
        r_ptr   <= w_next_ptr;
        r_lvl_x <= bus.req_x[int'(w_idx)*COORD_W +: COORD_W];
        r_lvl_y <= bus.req_y[int'(w_idx)*COORD_W +: COORD_W];
      end
    end
  end

  // Tag travels alongside the address so the result lands in the right slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vld <= '0;
      for (int s = 0; s < DEPTH; s++) begin
        r_tag[s] <= '0;
      end
    end else begin
      r_vld[0] <= w_any;
      r_tag[0] <= w_idx;
      for (int s = 1; s < DEPTH; s++) begin
        r_vld[s] <= r_vld[s-1];
        r_tag[s] <= r_tag[s-1];
      end
    end
  end

  assign w_cpl     = r_vld[DEPTH-1];
  assign w_cpl_tag = r_tag[DEPTH-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy <= '0;
      r_done <= '0;
      for (int i = 0; i < N_CH; i++) begin
        r_result[i] <= TYPE_W'(BLK_EMPTY);
      end
    end else begin
      r_busy <= (r_busy & ~w_cpl_oh) | w_gnt;
      r_done <= w_cpl_oh;
      for (int i = 0; i < N_CH; i++) begin
        if (w_cpl_oh[i]) begin
          r_result[i] <= lvl_data;
        end
      end
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign w_cpl_oh[i] = w_cpl && (w_cpl_tag == PW'(i));
    assign bus.result[i*TYPE_W +: TYPE_W] = r_result[i];
  end

  assign bus.gnt  = r_gnt;
  assign bus.done = r_done;
  assign bus.busy = r_busy;
  assign lvl_x    = r_lvl_x;
  assign lvl_y    = r_lvl_y;

  a_gnt_onehot : assert property (@(posedge clk) disable iff (!reset) $onehot0(r_gnt));
  a_done_onehot : assert property (@(posedge clk) disable iff (!reset) $onehot0(r_done));

endmodule

`default_nettype wire

// File: tb/tb_collision_arbiter.sv
// ---------------------------------------------------------------------------
// tb_collision_arbiter : vector table, directed corners and random traffic
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_collision_arbiter;
  import sk_defs::*;

  localparam int N  = 4;
  localparam int CW = 10;
  localparam int TW = 3;
  localparam int LAT = 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  collision_arbiter_if #(.N_CH(N), .COORD_W(CW), .TYPE_W(TW)) bus1 ();
  collision_arbiter_if #(.N_CH(N), .COORD_W(CW), .TYPE_W(TW)) bus0 ();
  collision_arbiter_if #(.N_CH(N), .COORD_W(CW), .TYPE_W(TW)) bus3 ();

  logic [CW-1:0] lvl_x1, lvl_y1, lvl_x0, lvl_y0, lvl_x3, lvl_y3;
  logic [TW-1:0] lvl_d1, lvl_d0, lvl_d3, d3a, d3b;

  function automatic logic [TW-1:0] lvl_f(input logic [CW-1:0] x, input logic [CW-1:0] y);
    int v;
    v = int'(x) * 3 + int'(y) * 5 + int'(x >> 4);
    return v[TW-1:0];
  endfunction

  always @(posedge clk) lvl_d1 <= lvl_f(lvl_x1, lvl_y1);
  assign lvl_d0 = lvl_f(lvl_x0, lvl_y0);
  always @(posedge clk) begin
    d3a    <= lvl_f(lvl_x3, lvl_y3);
    d3b    <= d3a;
    lvl_d3 <= d3b;
  end

  collision_arbiter #(.N_CH(N), .COORD_W(CW), .TYPE_W(TW), .LVL_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1), .lvl_x(lvl_x1), .lvl_y(lvl_y1), .lvl_data(lvl_d1));
  collision_arbiter #(.N_CH(N), .COORD_W(CW), .TYPE_W(TW), .LVL_LAT(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0), .lvl_x(lvl_x0), .lvl_y(lvl_y0), .lvl_data(lvl_d0));
  collision_arbiter #(.N_CH(N), .COORD_W(CW), .TYPE_W(TW), .LVL_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .bus(bus3), .lvl_x(lvl_x3), .lvl_y(lvl_y3), .lvl_data(lvl_d3));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: queue of in-flight lookups with absolute due cycles.
  typedef struct { int ch; int due; logic [TW-1:0] data; } fl_t;
  fl_t           m_q[$];
  int            cyc;
  int            m_ptr;
  logic [N-1:0]  m_busy, m_gnt, m_done;
  logic [N*TW-1:0] m_res;
  logic [CW-1:0] m_lx, m_ly;

  task automatic model_reset();
    m_q.delete();
    m_ptr = 0; m_busy = '0; m_gnt = '0; m_done = '0; m_res = '0; m_lx = '0; m_ly = '0;
  endtask

  task automatic model_edge();
    logic [N-1:0] elig;
    logic found;
    int c;
    cyc++;
    elig   = bus1.req & bus1.ch_en & ~m_busy;
    m_gnt  = '0;
    m_done = '0;
    if (m_q.size() > 0 && m_q[0].due == cyc) begin
      c = m_q[0].ch;
      m_done[c] = 1'b1;
      m_res[c*TW +: TW] = m_q[0].data;
      m_busy[c] = 1'b0;
      void'(m_q.pop_front());
    end
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      c = (m_ptr + k) % N;
      if (!found && elig[c]) begin
        found = 1'b1;
        m_gnt[c] = 1'b1;
        m_busy[c] = 1'b1;
        m_lx = bus1.req_x[c*CW +: CW];
        m_ly = bus1.req_y[c*CW +: CW];
        m_q.push_back('{c, cyc + LAT + 1, lvl_f(m_lx, m_ly)});
        m_ptr = (c + 1) % N;
      end
    end
  endtask

  task automatic compare_all();
    chk("gnt", 32'(bus1.gnt), 32'(m_gnt));
    chk("done", 32'(bus1.done), 32'(m_done));
    chk("busy", 32'(bus1.busy), 32'(m_busy));
    chk("result", 32'(bus1.result), 32'(m_res));
    chk("lvl_x", 32'(lvl_x1), 32'(m_lx));
    chk("lvl_y", 32'(lvl_y1), 32'(m_ly));
  endtask

  task automatic step();
    @(posedge clk);
    if (!reset) model_reset(); else model_edge();
    #1;
    compare_all();
  endtask

  task automatic set_xy(input int ch, input int x, input int y);
    bus1.req_x[ch*CW +: CW] = CW'(x);
    bus1.req_y[ch*CW +: CW] = CW'(y);
  endtask

  task automatic lat_check(input int sel, input logic [CW-1:0] x, input logic [CW-1:0] y);
    int n;
    logic seen;
    if (sel == 0) begin
      bus0.req_x[2*CW +: CW] = x; bus0.req_y[2*CW +: CW] = y; bus0.req = 4'b0100;
    end else begin
      bus3.req_x[2*CW +: CW] = x; bus3.req_y[2*CW +: CW] = y; bus3.req = 4'b0100;
    end
    seen = 1'b0;
    n = 0;
    while (!seen && n < 8) begin
      step();
      n++;
      seen = (sel == 0) ? bus0.gnt[2] : bus3.gnt[2];
    end
    chk("lat_gnt_seen", 32'(seen), 32'd1);
    bus0.req = '0;
    bus3.req = '0;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 10) begin
      step();
      n++;
      seen = (sel == 0) ? bus0.done[2] : bus3.done[2];
    end
    chk("lat_cycles", 32'(n), (sel == 0) ? 32'd1 : 32'd4);
    chk("lat_result", (sel == 0) ? 32'(bus0.result[2*TW +: TW]) : 32'(bus3.result[2*TW +: TW]),
        32'(lvl_f(x, y)));
  endtask

  typedef struct { logic [N-1:0] req; logic [N-1:0] en; logic [N-1:0] gnt; logic [N-1:0] done; } vec_t;
  vec_t tbl[12];

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{4'hF, 4'hF, 4'h1, 4'h0};
    tbl[1]  = '{4'hF, 4'hF, 4'h2, 4'h0};
    tbl[2]  = '{4'hF, 4'hF, 4'h4, 4'h1};
    tbl[3]  = '{4'hF, 4'hF, 4'h8, 4'h2};
    tbl[4]  = '{4'hF, 4'hF, 4'h1, 4'h4};
    tbl[5]  = '{4'hF, 4'hF, 4'h2, 4'h8};
    tbl[6]  = '{4'hF, 4'hB, 4'h8, 4'h1};
    tbl[7]  = '{4'hF, 4'hB, 4'h1, 4'h2};
    tbl[8]  = '{4'hF, 4'hB, 4'h2, 4'h8};
    tbl[9]  = '{4'hF, 4'hB, 4'h8, 4'h1};
    tbl[10] = '{4'h0, 4'hB, 4'h0, 4'h2};
    tbl[11] = '{4'h0, 4'hB, 4'h0, 4'h8};

    cyc = 0;
    model_reset();
    bus1.req = '0; bus1.ch_en = '1; bus1.req_x = '0; bus1.req_y = '0;
    bus0.req = '0; bus0.ch_en = '1; bus0.req_x = '0; bus0.req_y = '0;
    bus3.req = '0; bus3.ch_en = '1; bus3.req_x = '0; bus3.req_y = '0;

    // Reset held with random activity on the inputs.
    for (int i = 0; i < 5; i++) begin
      bus1.req = 4'($urandom); bus1.ch_en = 4'($urandom);
      bus1.req_x = 40'({$urandom, $urandom}); bus1.req_y = 40'({$urandom, $urandom});
      step();
    end
    @(negedge clk);
    reset = 1'b1;
    bus1.ch_en = '1;
    bus1.req = 4'b0010;
    set_xy(1, 40, 200);
    step();
    chk("rst_first_gnt", 32'(bus1.gnt), 32'h2);
    chk("rst_first_lx", 32'(lvl_x1), 32'd40);
    chk("rst_first_ly", 32'(lvl_y1), 32'd200);
    bus1.req = '0;
    step();
    step();
    chk("rst_first_done", 32'(bus1.done), 32'h2);
    chk("rst_first_res", 32'(bus1.result[1*TW +: TW]), 32'(lvl_f(10'd40, 10'd200)));

    // Fresh reset so the table starts from pointer 0 and idle channels.
    #2 reset = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < N; c++) set_xy(c, 10 * (c + 1) + 7, 300 + 13 * c);
    for (int i = 0; i < 12; i++) begin
      bus1.req   = tbl[i].req;
      bus1.ch_en = tbl[i].en;
      step();
      chk("tbl_gnt", 32'(bus1.gnt), 32'(tbl[i].gnt));
      chk("tbl_done", 32'(bus1.done), 32'(tbl[i].done));
    end
    chk("mask_res2_held", 32'(bus1.result[2*TW +: TW]), 32'(lvl_f(10'd37, 10'd326)));

    // Coordinates change after the grant edge.
    bus1.ch_en = '1;
    bus1.req = 4'b0001;
    set_xy(0, 100, 50);
    step();
    chk("chg_gnt", 32'(bus1.gnt), 32'h1);
    set_xy(0, 300, 50);
    step();
    step();
    chk("chg_res_old", 32'(bus1.result[0 +: TW]), 32'(lvl_f(10'd100, 10'd50)));
    step();
    chk("chg_regrant", 32'(bus1.gnt), 32'h1);
    chk("chg_lx_new", 32'(lvl_x1), 32'd300);
    bus1.req = '0;
    step();
    step();
    chk("chg_res_new", 32'(bus1.result[0 +: TW]), 32'(lvl_f(10'd300, 10'd50)));

    // Reset while two lookups are in flight.
    bus1.req = 4'b0011;
    step();
    step();
    chk("mid_busy_pre", 32'(bus1.busy), 32'h3);
    bus1.req = '0;
    #2 reset = 1'b0;
    model_reset();
    #1;
    chk("mid_busy_async", 32'(bus1.busy), 32'h0);
    chk("mid_done_async", 32'(bus1.done), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("mid_no_done", 32'(bus1.done), 32'h0);
    end

    // Latency sweep on the LVL_LAT=0 and LVL_LAT=3 instances.
    lat_check(0, 10'd123, 10'd45);
    lat_check(0, 10'd500, 10'd9);
    lat_check(3, 10'd77, 10'd600);
    lat_check(3, 10'd901, 10'd333);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      bus1.req   = 4'($urandom);
      bus1.ch_en = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'hF;
      if ($urandom_range(0, 2) == 0) begin
        bus1.req_x = 40'({$urandom, $urandom});
        bus1.req_y = 40'({$urandom, $urandom});
      end
      step();
    end
    bus1.req = '0;
    for (int i = 0; i < 4; i++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
